// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: the BTB entry layout at the
// default geometry, saturating counter arithmetic and the counter reset constants.
package bp_pkg;

  localparam int BP_XLEN   = 32;
  localparam int BP_IDX_W  = 6;
  localparam int BP_CTR_W  = 2;
  localparam int BP_TAG_W  = BP_XLEN - BP_IDX_W - 2;
  localparam int CTR_MAX_W = 4;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic [BP_CTR_W-1:0] ctr;
    logic                is_ret;
  } btb_entry_t;

  // Counters up to CTR_MAX_W bits wide travel through these helpers zero-extended.
  function automatic logic [CTR_MAX_W-1:0] ctr_inc(input logic [CTR_MAX_W-1:0] ctr,
                                                   input int w);
    logic [CTR_MAX_W-1:0] cap;
    cap = CTR_MAX_W'((1 << w) - 1);
    return (ctr >= cap) ? ctr : ctr + 1'b1;
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_dec(input logic [CTR_MAX_W-1:0] ctr);
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_weak_taken(input int w);
    return CTR_MAX_W'(1 << (w - 1));
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_weak_not_taken(input int w);
    return ctr_weak_taken(w) - 1'b1;
  endfunction

  localparam logic [CTR_MAX_W-1:0] CTR_WEAK_T  = ctr_weak_taken(BP_CTR_W);
  localparam logic [CTR_MAX_W-1:0] CTR_WEAK_NT = ctr_weak_not_taken(BP_CTR_W);

endpackage

// File: rtl/bp_ras.sv
// Circular return address stack. Pop is applied before push so a simultaneous
// call/return replaces the top; pushing when full overwrites the oldest entry.
module bp_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  stack_q [DEPTH];
  logic [XLEN-1:0]  stack_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_ptr;

  // ptr_q is the next free slot; the top sits one below it, modulo DEPTH.
  assign top_ptr = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;
  assign top     = stack_q[top_ptr];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));

  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (pop && cnt_q != '0) begin
      ptr_d = (ptr_d == '0) ? PTR_W'(DEPTH - 1) : ptr_d - 1'b1;
      cnt_d = cnt_d - 1'b1;
    end
    if (push) begin
      stack_d[ptr_d] = push_data;
      ptr_d = (ptr_d == PTR_W'(DEPTH - 1)) ? '0 : ptr_d + 1'b1;
      if (cnt_d != CNT_W'(DEPTH)) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    stack_q <= stack_d;
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters, queried combinationally by
// fetch and trained by EX. Defining BP_RAS_EN adds a return address stack.
module branch_predictor import bp_pkg::*; #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int CTR_W       = 2,
  parameter int RAS_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            u_valid,
  input  logic [XLEN-1:0] u_pc,
  input  logic            u_taken,
  input  logic [XLEN-1:0] u_target,
  input  logic            u_is_call,
  input  logic            u_is_ret
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
    logic             is_ret;
  } entry_t;

  entry_t btb_q [BTB_ENTRIES];
  entry_t btb_d [BTB_ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  entry_t           f_ent;
  logic             u_hit;
  logic             ras_empty;
  logic [XLEN-1:0]  ras_top;

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[XLEN-1:IDX_W+2];
  assign u_idx = u_pc[IDX_W+1:2];
  assign u_tag = u_pc[XLEN-1:IDX_W+2];
  assign f_ent = btb_q[f_idx];
  assign u_hit = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_tag);

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{f_pc[1:0], u_pc[1:0]};

`ifdef BP_RAS_EN
  logic ras_full;
  logic unused_ras_full;
  assign unused_ras_full = ras_full;

  bp_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (u_valid && u_is_call),
    .pop       (u_valid && u_is_ret),
    .push_data (u_pc + XLEN'(4)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  assign ras_empty = 1'b1;
  assign ras_top   = '0;
  logic unused_no_ras;
  assign unused_no_ras = ^{u_is_call, f_ent.is_ret, ras_top};
`endif

  always_comb begin
    pred_hit    = f_ent.valid && (f_ent.tag == f_tag);
    pred_taken  = pred_hit && f_ent.ctr[CTR_W-1];
    pred_target = pred_taken ? f_ent.target : f_pc + XLEN'(4);
`ifdef BP_RAS_EN
    if (pred_hit && f_ent.is_ret && !ras_empty) begin
      pred_taken  = 1'b1;
      pred_target = ras_top;
    end
`endif
  end

  always_comb begin
    btb_d = btb_q;
    if (u_valid) begin
      if (u_hit) begin
        if (u_taken) begin
          btb_d[u_idx].ctr    = CTR_W'(ctr_inc(CTR_MAX_W'(btb_q[u_idx].ctr), CTR_W));
          btb_d[u_idx].target = u_target;
        end else begin
          btb_d[u_idx].ctr    = CTR_W'(ctr_dec(CTR_MAX_W'(btb_q[u_idx].ctr)));
        end
      end else if (u_taken) begin
        btb_d[u_idx].valid  = 1'b1;
        btb_d[u_idx].tag    = u_tag;
        btb_d[u_idx].target = u_target;
        btb_d[u_idx].ctr    = CTR_W'(ctr_weak_taken(CTR_W));
        btb_d[u_idx].is_ret = u_is_ret;
      end
    end
  end

  // Reset clears only valid and the counter; tag/target are don't-care until allocated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (rst) begin
        btb_q[i].valid <= 1'b0;
        btb_q[i].ctr   <= CTR_W'(ctr_weak_not_taken(CTR_W));
      end else begin
        btb_q[i] <= btb_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic against a behavioural model. Covers BP_RAS_EN when the macro is defined.
module tb_branch_predictor;

  localparam int XLEN  = 32;
  localparam int N     = 64;
  localparam int CW    = 2;
  localparam int RD    = 4;
  localparam int IDX_W = 6;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] f_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            u_valid;
  logic [XLEN-1:0] u_pc;
  logic            u_taken;
  logic [XLEN-1:0] u_target;
  logic            u_is_call;
  logic            u_is_ret;

  branch_predictor #(
    .XLEN(XLEN), .BTB_ENTRIES(N), .CTR_W(CW), .RAS_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken), .u_target(u_target),
    .u_is_call(u_is_call), .u_is_ret(u_is_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: one record per index, counter as a plain integer.
  bit          m_valid  [N];
  longint      m_tag    [N];
  logic [31:0] m_target [N];
  int          m_ctr    [N];
  bit          m_ret    [N];
  logic [31:0] m_ras    [$];

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = (1 << (CW - 1)) - 1;
    end
    m_ras.delete();
  endfunction

  task automatic m_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                          output logic [31:0] tgt);
    int     idx;
    longint tg;
    idx = int'((pc >> 2) % N);
    tg  = longint'(pc >> (IDX_W + 2));
    hit = m_valid[idx] && (m_tag[idx] == tg);
    tk  = hit && (m_ctr[idx] >= (1 << (CW - 1)));
    tgt = tk ? m_target[idx] : pc + 32'd4;
`ifdef BP_RAS_EN
    if (hit && m_ret[idx] && m_ras.size() > 0) begin
      tk  = 1;
      tgt = m_ras[$];
    end
`endif
  endtask

  task automatic m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                          input bit call, input bit ret);
    int          idx;
    longint      tg;
    logic [31:0] ra;
    idx = int'((pc >> 2) % N);
    tg  = longint'(pc >> (IDX_W + 2));
    if (m_valid[idx] && m_tag[idx] == tg) begin
      if (tk) begin
        m_ctr[idx]    = (m_ctr[idx] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_ctr[idx] + 1;
        m_target[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[idx]  = 1;
      m_tag[idx]    = tg;
      m_target[idx] = tgt;
      m_ctr[idx]    = 1 << (CW - 1);
      m_ret[idx]    = ret;
    end
`ifdef BP_RAS_EN
    if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
    if (call) begin
      ra = pc + 32'd4;
      m_ras.push_back(ra);
      if (m_ras.size() > RD) void'(m_ras.pop_front());
    end
`else
    ra = '0;
    if (call && ret && ra != '0) m_ras.delete();
`endif
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tgt, input bit call, input bit ret);
    u_valid = v; u_pc = pc; u_taken = tk; u_target = tgt; u_is_call = call; u_is_ret = ret;
  endtask

  task automatic set_idle();
    set_upd(0, '0, 0, '0, 0, 0);
  endtask

  // Explicit expectations at the current inputs, before the next edge.
  task automatic peek(input string tag, input logic [31:0] fpc, input bit eh, input bit et,
                      input logic [31:0] eg);
    f_pc = fpc;
    #1;
    check({tag, "_hit"}, pred_hit, eh);
    check({tag, "_taken"}, pred_taken, et);
    check({tag, "_target"}, pred_target, eg);
  endtask

  // One clock: compare against the model, clock the DUT, advance the model.
  task automatic step(input string tag, input logic [31:0] fpc);
    bit          eh, et;
    logic [31:0] eg;
    f_pc = fpc;
    #1;
    m_lookup(fpc, eh, et, eg);
    check({tag, "_hit"}, pred_hit, eh);
    check({tag, "_taken"}, pred_taken, et);
    check({tag, "_target"}, pred_target, eg);
    @(posedge clk);
    if (rst) m_reset();
    else if (u_valid) m_update(u_pc, u_taken, u_target, u_is_call, u_is_ret);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
       | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) pc = pc | 32'hFFFF_FF00;
    return pc;
  endfunction

  initial begin
    rst = 1'b1;
    f_pc = '0;
    set_idle();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    peek("reset", 32'h100, 0, 0, 32'h104);
    step("reset", 32'h100);

    // Allocation: same-cycle lookup still sees the old state.
    set_upd(1, 32'h100, 1, 32'h200, 0, 0);
    peek("same_cycle", 32'h100, 0, 0, 32'h104);
    step("alloc", 32'h100);
    set_idle();
    peek("after_alloc", 32'h100, 1, 1, 32'h200);
    step("after_alloc", 32'h100);

    set_upd(1, 32'h100, 0, 32'h0, 0, 0);
    step("nt1", 32'h100);
    step("nt2", 32'h100);
    set_idle();
    peek("ctr0", 32'h100, 1, 0, 32'h104);
    set_upd(1, 32'h100, 0, 32'h0, 0, 0);
    step("nt3", 32'h100);
    set_upd(1, 32'h100, 1, 32'h240, 0, 0);
    step("tk1", 32'h100);
    set_idle();
    peek("ctr_floor", 32'h100, 1, 0, 32'h104);
    set_upd(1, 32'h100, 1, 32'h240, 0, 0);
    step("tk2", 32'h100);
    set_idle();
    peek("ctr2", 32'h100, 1, 1, 32'h240);
    step("ctr2", 32'h100);

    // Alias at the same index evicts the first entry.
    set_upd(1, 32'h200, 1, 32'h300, 0, 0);
    step("alias", 32'h200);
    set_idle();
    peek("alias_evict", 32'h100, 0, 0, 32'h104);
    peek("alias_new", 32'h200, 1, 1, 32'h300);
    step("alias_chk", 32'h200);

    peek("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);
    step("wrap", 32'hFFFF_FFFC);

    // Reset overrides a simultaneous update.
    set_upd(1, 32'h400, 1, 32'h500, 0, 0);
    rst = 1'b1;
    step("rst_upd", 32'h400);
    rst = 1'b0;
    set_idle();
    peek("rst_drop", 32'h400, 0, 0, 32'h404);
    peek("rst_clear", 32'h200, 0, 0, 32'h204);
    step("rst_drop", 32'h400);

    // Return entry, then five calls, then five returns.
    set_upd(1, 32'h800, 1, 32'h900, 0, 1);
    step("ret_alloc", 32'h800);
    for (int i = 1; i <= 5; i++) begin
      set_upd(1, 32'(i * 16), 1, 32'h1000, 1, 0);
      step("call", 32'h800);
    end
    for (int i = 0; i < 5; i++) begin
      logic [31:0] exp_t;
`ifdef BP_RAS_EN
      exp_t = (i < 4) ? 32'(32'h54 - i * 16) : 32'h900;
`else
      exp_t = 32'h900;
`endif
      set_upd(1, 32'h800, 1, 32'h900, 0, 1);
      peek("ret", 32'h800, 1, 1, exp_t);
      step("ret", 32'h800);
    end
    set_idle();

    for (int i = 0; i < 500; i++) begin
      set_upd($urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 9) < 6,
              32'($urandom) & 32'hFFFF_FFFC, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 63) == 0);
      step("rand", rand_pc());
    end
    rst = 1'b0;
    set_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
